chan_scan_mux: RTL
==================

Name: chan_scan_mux

Overview:
- Registered, parametrised N-channel multiplexer; successor to the fixed 8:1 combinational mux.
- Two modes:
  - Manual: fixed channel, sampled every free slot.
  - Scan: channels visited in round-robin order, each held for DWELL cycles.
- Output is a registered sample with valid/ready handshake.
- Sits between parallel sensor/switch inputs and a single serial consumer (display driver, UART packer).

Parameters:
- NUM_CH, 8, number of input channels (>=2).
- DATA_W, 8, bits per channel.
- DWELL, 4, scan-mode cycles per channel before sampling (>=1).
- SEL_W, $clog2(NUM_CH), localparam, select width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mode  in  1  0 = manual, 1 = scan.
- sel_in  in  SEL_W  channel index to load.
- sel_load  in  1  one-cycle pulse; latches sel_in.
- din  in  NUM_CH*DATA_W  packed channels; channel k = din[k*DATA_W +: DATA_W].
- dout  out  DATA_W  registered sample.
- dout_ch  out  SEL_W  channel index of the sample in dout.
- dout_valid  out  1  sample available.
- dout_ready  in  1  consumer accepts when dout_valid & dout_ready.
- cur_sel  out  SEL_W  current selection register sel_q.
- sel_err  out  1  sticky; set on an illegal load.

Behaviour:
- Single clock. Reset is synchronous, active-low (rst_n sampled on clk rising edge).
- Reset values: dout=0, dout_ch=0, dout_valid=0, sel_q=0, dwell cnt=0, sel_err=0.
- Reset mid-transfer drops any pending sample; no handshake completes in the reset cycle.
- slot_free = !dout_valid | dout_ready.
- Capture: dout<=din[sel_q], dout_ch<=sel_q, dout_valid<=1. Latency is 1 cycle from capture condition to dout.
- If slot_free and no capture, dout_valid<=0.
- If !slot_free, dout, dout_ch and dout_valid hold stable.
- sel_load with sel_in < NUM_CH: sel_q<=sel_in next cycle, cnt<=0.
- sel_load with sel_in >= NUM_CH: ignored and sel_err<=1. sel_err clears only on reset.
- Manual mode (mode=0):
  - Capture every cycle slot_free is true.
  - Cycle of a legal sel_load: capture uses the old sel_q.
- Scan mode (mode=1), counter cnt runs 0..DWELL-1:
  - cnt<DWELL-1: cnt++, no capture.
  - cnt==DWELL-1 and slot_free: capture, cnt<=0, sel_q<=next channel. Next wraps NUM_CH-1 -> 0.
  - cnt==DWELL-1 and !slot_free: stall. cnt and sel_q hold; no channel is skipped.
- Mode 0->1 transition: cnt<=0, scanning starts at current sel_q.
- Mode 1->0 transition: sel_q keeps its last value.
- sel_load during scan: reloads sel_q and restarts cnt.
- Simultaneous sel_load and scan terminal count: sel_load wins. Capture uses the old sel_q, then sel_q<=sel_in, cnt<=0.

Optional Feature:
- Macro: CHAN_MASK_EN.
- With the macro:
  - Adds input port ch_mask (NUM_CH bits, 1 = enabled).
  - Scan advance picks the next enabled channel in ascending wrap order.
  - A disabled sel_q never captures; it advances to the next enabled channel immediately.
  - All channels masked: no captures, dout_valid drains to 0, sel_q holds.
  - Manual load of a masked channel: sel_err<=1, load ignored.
- Without the macro: no ch_mask port, all channels enabled, advance is plain +1 wrap.

Decomposition:
- Package chan_scan_pkg holds:
  - mode constants MODE_MANUAL=0, MODE_SCAN=1;
  - clog2 helper function;
  - default NUM_CH/DATA_W/DWELL constants.
- One sub-module, dwell_counter:
  - parameter DWELL;
  - inputs en, clr, stall;
  - output tc (terminal count).
- Mux selection, next-channel logic and the output register stay in chan_scan_mux.

Test Plan:
- Reset: rst_n=0 for 2 cycles with din all 0xFF -> dout=0, dout_valid=0, cur_sel=0, sel_err=0.
- Manual: mode=0, sel_load with sel_in=5, ch5=0xA5, dout_ready=1 -> 2 cycles after the load pulse, dout=0xA5, dout_ch=5, dout_valid=1 every cycle.
- Scan wrap: NUM_CH=8, DWELL=4, channel k = k, dout_ready=1, start sel_q=6 -> captures of 6,7,0,1 at 4-cycle intervals.
- Backpressure: scan mode, hold dout_ready=0 for 10 cycles after a capture of ch2:
  - dout=2 stays stable;
  - cur_sel=3 and does not advance;
  - on release, ch3 is captured in the same cycle as the handshake.
- Illegal load: NUM_CH=6, sel_in=7 with sel_load -> sel_err=1, cur_sel unchanged, sel_err remains set until reset.
- CHAN_MASK_EN build: ch_mask=8'b1000_0101, scan -> capture order 0,2,7,0. Then ch_mask=0 -> dout_valid goes low after the pending sample drains, and no further captures.

Source files
------------

// File: rtl/chan_scan_mux_pkg.sv
// chan_scan_pkg: shared constants and helpers for the channel scan multiplexer.
package chan_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DWELL  = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/chan_scan_mux_dwell_counter.sv
// dwell_counter: counts 0..DWELL-1 while enabled; tc flags the last cycle.
// At terminal count the counter waits there while stall is high, so the
// channel being dwelt on is never skipped. Disabled or cleared -> 0.
module dwell_counter
  import chan_scan_pkg::*;
#(
  parameter int DWELL = DEF_DWELL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic stall,
  output logic tc
);

  localparam int CNT_W = (DWELL > 1) ? clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == LAST);

  // Next count: clear, hold at terminal count under stall, else step/wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      if (!stall) cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel mux with manual and round-robin scan
// modes. Optional build macro CHAN_MASK_EN adds a per-channel enable mask.
//
// Handshake: dout/dout_ch are meaningful while dout_valid is high and stay
// stable until the cycle dout_valid & dout_ready, when the sample is taken;
// a new sample may be captured in that same cycle (slot_free).
module chan_scan_mux
  import chan_scan_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DWELL  = DEF_DWELL,
  localparam int SEL_W  = clog2(NUM_CH)
) (
`ifdef CHAN_MASK_EN
  input  logic [NUM_CH-1:0]        ch_mask,
`endif
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     sel_load,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic [DATA_W-1:0]        dout,
  output logic [SEL_W-1:0]         dout_ch,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     sel_err
);

  logic [DATA_W-1:0] dout_q, dout_d;
  logic [SEL_W-1:0]  dout_ch_q, dout_ch_d;
  logic              dout_valid_q, dout_valid_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              sel_err_q, sel_err_d;

  logic [NUM_CH-1:0] en_mask;
  logic              slot_free, is_scan, sel_en, load_ok, capture, tc, cnt_clr;
  logic [SEL_W-1:0]  next_ch;
  logic [DATA_W-1:0] cap_data;

`ifdef CHAN_MASK_EN
  assign en_mask = ch_mask;
  assign load_ok = sel_load && (int'(sel_in) < NUM_CH) && ch_mask[sel_in];
`else
  assign en_mask = '1;
  assign load_ok = sel_load && (int'(sel_in) < NUM_CH);
`endif

  assign slot_free = !dout_valid_q || dout_ready;
  assign is_scan   = (mode == MODE_SCAN);
  assign sel_en    = en_mask[sel_q];
  assign capture   = slot_free && sel_en && (!is_scan || tc);
  // Restart the dwell on a legal load, and while parked on a disabled channel.
  assign cnt_clr   = load_ok || (is_scan && !sel_en);

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (is_scan),
    .clr   (cnt_clr),
    .stall (!slot_free),
    .tc    (tc)
  );

  // Next enabled channel in ascending wrap order; holds sel_q if none.
  always_comb begin
    int idx;
    logic found;
    next_ch = sel_q;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(sel_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && en_mask[SEL_W'(idx)]) begin
        next_ch = SEL_W'(idx);
        found   = 1'b1;
      end
    end
  end

  // Channel data selected by sel_q.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == SEL_W'(k)) cap_data = din[k*DATA_W +: DATA_W];
    end
  end

  // Output slot, selection and error next-state. A load wins over the scan
  // advance; the capture in the same cycle still uses the old sel_q.
  always_comb begin
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = dout_valid_q;
    sel_d        = sel_q;
    sel_err_d    = sel_err_q || (sel_load && !load_ok);
    if (slot_free) begin
      dout_valid_d = capture;
      if (capture) begin
        dout_d    = cap_data;
        dout_ch_d = sel_q;
      end
    end
    if (load_ok) begin
      sel_d = sel_in;
    end else if (is_scan && (capture || !sel_en)) begin
      sel_d = next_ch;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      sel_q        <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      sel_q        <= sel_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign cur_sel    = sel_q;
  assign sel_err    = sel_err_q;

endmodule
